// File: rtl/fir_pkg.sv
// Shared types and index helpers for the FIR tap sequencer.
package fir_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        RUN   = 2'd2
    } seq_state_t;

    // Delay-line slot holding x[n-k]; explicit wrap so non-power-of-2 depths work.
    function automatic int unsigned tap_idx(
        input int unsigned newest,
        input int unsigned k,
        input int unsigned ntaps
    );
        return (newest >= k) ? (newest - k) : (newest + ntaps - k);
    endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Circular sample buffer: one write port, one clear-write port, combinational read.
module fir_delay_line #(
    parameter int unsigned DW    = 24,
    parameter int unsigned NTAPS = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(NTAPS)-1:0] wr_addr,
    input  logic [DW-1:0]            wr_data,
    input  logic                     clr_en,
    input  logic [$clog2(NTAPS)-1:0] clr_addr,
    input  logic [$clog2(NTAPS)-1:0] rd_addr,
    output logic [DW-1:0]            rd_data
);

    logic [DW-1:0] mem [NTAPS];

    // Contents are zeroed by the sequencer's clear sweep, so no reset here.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_addr] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fir_tap_sequencer.sv
// Turns each input sample into one frame of NTAPS (sample, coefficient) pairs for the Macc.
module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter int unsigned DW    = 24,
    parameter int unsigned CW    = 18,
    parameter int unsigned NTAPS = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DW-1:0]            s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     coef_wr_en,
    input  logic [$clog2(NTAPS)-1:0] coef_wr_addr,
    input  logic [CW-1:0]            coef_wr_data,
    output logic                     coef_wr_ready,
    output logic [DW-1:0]            m_axis_atdata,
    output logic                     m_axis_atvalid,
    input  logic                     m_axis_atready,
    output logic                     m_axis_atlast,
    output logic [CW-1:0]            m_axis_btdata,
    output logic                     m_axis_btvalid,
    input  logic                     m_axis_btready
);

    localparam int unsigned    AW   = $clog2(NTAPS);
    localparam logic [AW-1:0]  LAST = AW'(NTAPS - 1);

    seq_state_t    state, state_n;
    logic [AW-1:0] clr_cnt, clr_cnt_n;
    logic [AW-1:0] wr_ptr, wr_ptr_n;
    logic [AW-1:0] newest, newest_n;
    logic [AW-1:0] k, k_n, k_inc, rd_addr;
    logic          a_pend, a_pend_n, b_pend, b_pend_n;
    logic          idle_q, idle_n;
    logic [DW-1:0] atdata_n, rd_data;
    logic [CW-1:0] btdata_n, coef0_fwd;
    logic          atlast_n;
    logic          s_hs, coef_we, addr_ok, a_hs, b_hs, a_done, b_done;
    logic          clr_en, dl_wr_en;
    logic [CW-1:0] coef [NTAPS];

    assign s_axis_tready  = idle_q;
    assign coef_wr_ready  = idle_q;
    assign m_axis_atvalid = a_pend;
    assign m_axis_btvalid = b_pend;

    assign s_hs    = idle_q && s_axis_tvalid;
    assign coef_we = idle_q && coef_wr_en && addr_ok;
    assign a_hs    = a_pend && m_axis_atready;
    assign b_hs    = b_pend && m_axis_btready;
    assign a_done  = !a_pend || a_hs;
    assign b_done  = !b_pend || b_hs;
    assign k_inc   = (k == LAST) ? '0 : k + AW'(1);
    assign rd_addr = AW'(tap_idx(32'(newest), 32'(k_inc), NTAPS));

    // A write landing in the handshake cycle must reach the first B of that frame.
    assign coef0_fwd = (coef_we && coef_wr_addr == '0) ? coef_wr_data : coef[0];

    if (NTAPS == (32'd1 << AW)) begin : g_pow2
        assign addr_ok = 1'b1;
    end else begin : g_npow2
        assign addr_ok = (32'(coef_wr_addr) < NTAPS);
    end

    fir_delay_line #(
        .DW    (DW),
        .NTAPS (NTAPS)
    ) u_delay (
        .clk      (clk),
        .wr_en    (dl_wr_en),
        .wr_addr  (wr_ptr),
        .wr_data  (s_axis_tdata),
        .clr_en   (clr_en),
        .clr_addr (clr_cnt),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    // Coefficient register file survives reset.
    always_ff @(posedge clk) begin
        if (coef_we) begin
            coef[coef_wr_addr] <= coef_wr_data;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n   = state;
        clr_cnt_n = clr_cnt;
        wr_ptr_n  = wr_ptr;
        newest_n  = newest;
        k_n       = k;
        a_pend_n  = a_pend;
        b_pend_n  = b_pend;
        atdata_n  = m_axis_atdata;
        btdata_n  = m_axis_btdata;
        atlast_n  = m_axis_atlast;
        clr_en    = 1'b0;
        dl_wr_en  = 1'b0;

        case (state)
            CLEAR: begin
                clr_en = 1'b1;
                if (clr_cnt == LAST) begin
                    clr_cnt_n = '0;
                    state_n   = IDLE;
                end else begin
                    clr_cnt_n = clr_cnt + AW'(1);
                end
            end
            IDLE: begin
                if (s_hs) begin
                    dl_wr_en = 1'b1;
                    newest_n = wr_ptr;
                    k_n      = '0;
                    atdata_n = s_axis_tdata;
                    btdata_n = coef0_fwd;
                    atlast_n = 1'b0;
                    a_pend_n = 1'b1;
                    b_pend_n = 1'b1;
                    state_n  = RUN;
                end
            end
            RUN: begin
                if (a_hs) a_pend_n = 1'b0;
                if (b_hs) b_pend_n = 1'b0;
                // Advance only once both halves of pair k have been taken.
                if (a_done && b_done) begin
                    if (k == LAST) begin
                        wr_ptr_n = (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
                        atlast_n = 1'b0;
                        state_n  = IDLE;
                    end else begin
                        k_n      = k_inc;
                        atdata_n = rd_data;
                        btdata_n = coef[k_inc];
                        atlast_n = (k_inc == LAST);
                        a_pend_n = 1'b1;
                        b_pend_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = CLEAR;
            end
        endcase

        idle_n = (state_n == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= CLEAR;
            clr_cnt       <= '0;
            wr_ptr        <= '0;
            newest        <= '0;
            k             <= '0;
            a_pend        <= 1'b0;
            b_pend        <= 1'b0;
            idle_q        <= 1'b0;
            m_axis_atdata <= '0;
            m_axis_btdata <= '0;
            m_axis_atlast <= 1'b0;
        end else begin
            state         <= state_n;
            clr_cnt       <= clr_cnt_n;
            wr_ptr        <= wr_ptr_n;
            newest        <= newest_n;
            k             <= k_n;
            a_pend        <= a_pend_n;
            b_pend        <= b_pend_n;
            idle_q        <= idle_n;
            m_axis_atdata <= atdata_n;
            m_axis_btdata <= btdata_n;
            m_axis_atlast <= atlast_n;
        end
    end

endmodule
